rs_age_station: RTL and testbench
=================================

// Module: rs_age_station
// PURPOSE
//  Parametrised reservation station that replaces the fixed 16-entry, 2-CDB, lowest-index-select station.
//  Holds issued ALU ops until both operands are valid. Operands are captured from NUM_CDB result buses.
//  Dispatches the OLDEST ready entry into a registered ALU output with valid/ready backpressure.
//  Sits between the issue stage (decoder/ROB rename) and the ALU. Provides almost-full credit, occupancy and overflow flags.
// PARAMETERS
//  DEPTH       16  number of entries (power of two, >=2)
//  DATA_W      32  operand width
//  TAG_W       4   ROB tag width
//  OP_W        5   ALU opcode width
//  NUM_CDB     2   number of result broadcast ports
//  AF_MARGIN   2   free-slot reserve below which issue_ready deasserts (1..DEPTH-1)
// PORTS
//  clk            in   1                 clock
//  rst            in   1                 synchronous active-high reset
//  rdy            in   1                 global enable; 0 = freeze all state
//  flush          in   1                 mispredict: discard all entries and output
//  issue_valid    in   1                 new op present this cycle
//  issue_op       in   OP_W              ALU opcode
//  issue_vj/vk    in   DATA_W each       operand values (used when q*_valid=0)
//  issue_qj/qk_valid in 1 each           operand pending on tag
//  issue_qj/qk    in   TAG_W each        producer tags
//  issue_tag      in   TAG_W             destination ROB tag
//  issue_ready    out  1                 registered credit: (count_next <= DEPTH-AF_MARGIN)
//  cdb_valid      in   NUM_CDB           per-port broadcast valid
//  cdb_tag        in   NUM_CDB*TAG_W     port p at [p*TAG_W +: TAG_W]
//  cdb_data       in   NUM_CDB*DATA_W    port p at [p*DATA_W +: DATA_W]
//  alu_valid      out  1                 output holds an op
//  alu_ready      in   1                 ALU accepts op this cycle
//  alu_op         out  OP_W              opcode
//  alu_a/alu_b    out  DATA_W each       operands
//  alu_tag        out  TAG_W             destination tag
//  count          out  $clog2(DEPTH+1)   occupied entries (excluding output reg)
//  overflow_err   out  1                 sticky: issue_valid arrived with no free entry
// BEHAVIOUR
//  Reset: all entries invalid. alu_valid, alu_op/a/b/tag, count and overflow_err are 0. issue_ready is 0 during reset and 1 on the first cycle after.
//  rdy=0: no state changes (entries, output reg, count, flags), even if issue_valid or cdb_valid is high.
//  Issue: accepted iff issue_valid and a free entry exists. issue_ready is advisory.
//    Entry chosen is the lowest-index free entry.
//    No free entry: the op is dropped and overflow_err is set (it clears only on rst).
//  Issue-time forwarding: if an operand is pending and cdb_valid[p] with cdb_tag[p] equal to its tag, capture cdb_data[p] and mark the operand valid.
//    If several ports match, the lowest p wins. Otherwise store issue value and tag.
//  Wakeup: every valid entry with a pending operand that matches any valid CDB port captures the data (lowest p wins).
//    The entry is eligible for select from the NEXT cycle. There is no same-cycle wakeup-and-dispatch.
//  Age: a DEPTH x DEPTH age matrix. On allocation of entry i, set older[j][i]=1 for every valid j and clear older[i][*].
//    Free entries are ignored in comparisons.
//  Select: the ready entry (both operands valid) that no other ready entry is older than. At most one per cycle.
//  Dispatch: when (!alu_valid || alu_ready) and a ready entry exists, load the output reg from it, set alu_valid=1 and free the entry.
//    If (alu_valid && alu_ready) and no ready entry exists, set alu_valid=0.
//    If alu_valid && !alu_ready, the output reg holds all values stable.
//  An entry freed by dispatch is not reusable by issue in the same cycle. An issue and a dispatch may both happen in one cycle.
//  count_next = count + accept - dispatch, clamped to 0..DEPTH by construction.
//  issue_ready is registered from count_next, giving one cycle of latency.
//    AF_MARGIN covers in-flight ops from upstream.
//  Flush: takes priority over issue, wakeup and dispatch in the same cycle.
//    All entries are invalidated; alu_valid=0, count=0, issue_ready=1 next cycle. overflow_err is unchanged.
//  Reset mid-operation behaves the same as flush and also clears overflow_err and the age matrix.
//    Reset has priority over rdy=0.
// TESTING (DEPTH=16, AF_MARGIN=2, NUM_CDB=2)
//  1 alu_ready=0; issue 17 ready ops tags 0..16 mod 16 -> first op held at the output and count reaches 16.
//    issue_ready falls the cycle after count_next hits 15. An 18th issue sets overflow_err=1 and count stays 16.
//  2 Issue A(tag3, qj=5) then B(tag7, ready), then cdb0 tag5 data 0xDEAD -> B dispatches first.
//    A dispatches with alu_a=0xDEAD, one cycle after the broadcast at the earliest.
//  3 Issue C(tag1, qk=6) then D(tag2, qk=6); cdb1 tag6 data 0x55 -> C dispatches before D; both get alu_b=0x55.
//  4 Issue E(qj=9) in the same cycle as cdb1 tag9 data 0x1234 -> E is stored ready and dispatches the next cycle with alu_a=0x1234.
//  5 Six entries queued with alu_valid=1; assert flush together with issue_valid and cdb_valid.
//    Next cycle: count=0, alu_valid=0, the new op is absent, issue_ready=1.
//  6 Drop rdy for 3 cycles while toggling issue/cdb/alu_ready -> all outputs unchanged.
//    Assert rst mid-stream -> all outputs reach their reset values the next cycle.

Source files
------------

// File: rtl/rs_age_station.sv
// rs_age_station: age-ordered reservation station for ALU ops.
//   Holds issued ops until both operands are valid. Operands arrive either with
//   the op or later from NUM_CDB result buses. Each cycle the oldest ready entry
//   moves into a registered ALU output stage that has valid/ready handshaking.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rdy               global enable (0 freezes all state)
//   flush             discard every entry and the output stage
//   issue_*           incoming op: opcode, operand values, pending tags, dest tag
//   issue_ready       registered almost-full credit toward the issue stage
//   cdb_valid/tag/data  result broadcast ports, port p packed at p*W
//   alu_*             registered output op with valid/ready handshake
//   count             occupied entries, not counting the output stage
//   overflow_err      sticky flag: an op arrived when no entry was free
module rs_age_station #(
  parameter int DEPTH     = 16,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 4,
  parameter int OP_W      = 5,
  parameter int NUM_CDB   = 2,
  parameter int AF_MARGIN = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         flush,
  input  logic                         issue_valid,
  input  logic [OP_W-1:0]              issue_op,
  input  logic [DATA_W-1:0]            issue_vj,
  input  logic [DATA_W-1:0]            issue_vk,
  input  logic                         issue_qj_valid,
  input  logic                         issue_qk_valid,
  input  logic [TAG_W-1:0]             issue_qj,
  input  logic [TAG_W-1:0]             issue_qk,
  input  logic [TAG_W-1:0]             issue_tag,
  output logic                         issue_ready,
  input  logic [NUM_CDB-1:0]           cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]     cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]    cdb_data,
  output logic                         alu_valid,
  input  logic                         alu_ready,
  output logic [OP_W-1:0]              alu_op,
  output logic [DATA_W-1:0]            alu_a,
  output logic [DATA_W-1:0]            alu_b,
  output logic [TAG_W-1:0]             alu_tag,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow_err
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]  ent_valid, ent_pj, ent_pk;
  logic [OP_W-1:0]   ent_op  [DEPTH];
  logic [DATA_W-1:0] ent_vj  [DEPTH];
  logic [DATA_W-1:0] ent_vk  [DEPTH];
  logic [TAG_W-1:0]  ent_qj  [DEPTH];
  logic [TAG_W-1:0]  ent_qk  [DEPTH];
  logic [TAG_W-1:0]  ent_tag [DEPTH];
  // older[j][i] = 1 means entry j was allocated before entry i
  logic [DEPTH-1:0]  older     [DEPTH];
  logic [DEPTH-1:0]  older_col [DEPTH];

  logic [DEPTH-1:0]  wake_j, wake_k;
  logic [DATA_W-1:0] wake_dj [DEPTH];
  logic [DATA_W-1:0] wake_dk [DEPTH];
  logic              fwd_j, fwd_k;
  logic [DATA_W-1:0] fwd_dj, fwd_dk;

  logic [DEPTH-1:0]  ent_ready, sel_oh;
  logic [IDX_W-1:0]  sel_idx, free_idx;
  logic              any_ready, any_free, do_load, accept, dispatch;
  logic [CNT_W-1:0]  count_next;

  // CDB match. Ports are scanned from the highest index down so that the
  // lowest matching port is the last assignment and wins.
  always_comb begin
    wake_j = '0;
    wake_k = '0;
    fwd_j  = 1'b0;
    fwd_k  = 1'b0;
    fwd_dj = issue_vj;
    fwd_dk = issue_vk;
    for (int i = 0; i < DEPTH; i++) begin
      wake_dj[i] = ent_vj[i];
      wake_dk[i] = ent_vk[i];
    end
    for (int p = NUM_CDB-1; p >= 0; p--) begin
      if (cdb_valid[p]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ent_qj[i] == cdb_tag[p*TAG_W +: TAG_W]) begin
            wake_j[i]  = 1'b1;
            wake_dj[i] = cdb_data[p*DATA_W +: DATA_W];
          end
          if (ent_qk[i] == cdb_tag[p*TAG_W +: TAG_W]) begin
            wake_k[i]  = 1'b1;
            wake_dk[i] = cdb_data[p*DATA_W +: DATA_W];
          end
        end
        if (issue_qj == cdb_tag[p*TAG_W +: TAG_W]) begin
          fwd_j  = 1'b1;
          fwd_dj = cdb_data[p*DATA_W +: DATA_W];
        end
        if (issue_qk == cdb_tag[p*TAG_W +: TAG_W]) begin
          fwd_k  = 1'b1;
          fwd_dk = cdb_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Oldest-ready select: a ready entry wins when no other ready entry is older.
  always_comb begin
    ent_ready = ent_valid & ~ent_pj & ~ent_pk;
    sel_oh    = '0;
    sel_idx   = '0;
    free_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        older_col[i][j] = older[j][i] && (j != i);
      end
      sel_oh[i] = ent_ready[i] && !(|(ent_ready & older_col[i]));
    end
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (sel_oh[i])     sel_idx  = IDX_W'(i);
      if (!ent_valid[i]) free_idx = IDX_W'(i);
    end
  end

  assign any_ready  = |ent_ready;
  assign any_free   = ~&ent_valid;
  assign do_load    = !alu_valid || alu_ready;
  assign accept     = issue_valid && any_free;
  assign dispatch   = do_load && any_ready;
  assign count_next = count + CNT_W'(accept) - CNT_W'(dispatch);

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid    <= '0;
      ent_pj       <= '0;
      ent_pk       <= '0;
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
      alu_valid    <= 1'b0;
      alu_op       <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_tag      <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
      issue_ready  <= 1'b0;
    end else if (rdy) begin
      if (flush) begin
        ent_valid   <= '0;
        alu_valid   <= 1'b0;
        count       <= '0;
        issue_ready <= 1'b1;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ent_valid[i] && ent_pj[i] && wake_j[i]) ent_pj[i] <= 1'b0;
          if (ent_valid[i] && ent_pk[i] && wake_k[i]) ent_pk[i] <= 1'b0;
        end
        if (do_load) begin
          if (any_ready) begin
            alu_valid          <= 1'b1;
            alu_op             <= ent_op[sel_idx];
            alu_a              <= ent_vj[sel_idx];
            alu_b              <= ent_vk[sel_idx];
            alu_tag            <= ent_tag[sel_idx];
            ent_valid[sel_idx] <= 1'b0;
          end else begin
            alu_valid <= 1'b0;
          end
        end
        if (issue_valid) begin
          if (any_free) begin
            ent_valid[free_idx] <= 1'b1;
            ent_pj[free_idx]    <= issue_qj_valid && !fwd_j;
            ent_pk[free_idx]    <= issue_qk_valid && !fwd_k;
            older[free_idx]     <= '0;
            for (int j = 0; j < DEPTH; j++) older[j][free_idx] <= ent_valid[j];
          end else begin
            overflow_err <= 1'b1;
          end
        end
        count       <= count_next;
        issue_ready <= (count_next <= CNT_W'(DEPTH - AF_MARGIN));
      end
    end
  end

  // Entry payload carries no reset: the valid/pending bits qualify it.
  always_ff @(posedge clk) begin
    if (!rst && rdy && !flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_pj[i] && wake_j[i]) ent_vj[i] <= wake_dj[i];
        if (ent_pk[i] && wake_k[i]) ent_vk[i] <= wake_dk[i];
      end
      if (accept) begin
        ent_op[free_idx]  <= issue_op;
        ent_tag[free_idx] <= issue_tag;
        ent_qj[free_idx]  <= issue_qj;
        ent_qk[free_idx]  <= issue_qk;
        ent_vj[free_idx]  <= (issue_qj_valid && fwd_j) ? fwd_dj : issue_vj;
        ent_vk[free_idx]  <= (issue_qk_valid && fwd_k) ? fwd_dk : issue_vk;
      end
    end
  end
endmodule

// File: tb/tb_rs_age_station.sv
// tb_rs_age_station: directed scenarios plus randomized traffic, checked every
// cycle against an age-ordered queue model of the reservation station.
module tb_rs_age_station;
  localparam int DEPTH     = 16;
  localparam int DATA_W    = 32;
  localparam int TAG_W     = 4;
  localparam int OP_W      = 5;
  localparam int NUM_CDB   = 2;
  localparam int AF_MARGIN = 2;
  localparam int CNT_W     = $clog2(DEPTH+1);

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      rdy = 1'b1;
  logic                      flush = 1'b0;
  logic                      issue_valid = 1'b0;
  logic [OP_W-1:0]           issue_op = '0;
  logic [DATA_W-1:0]         issue_vj = '0, issue_vk = '0;
  logic                      issue_qj_valid = 1'b0, issue_qk_valid = 1'b0;
  logic [TAG_W-1:0]          issue_qj = '0, issue_qk = '0, issue_tag = '0;
  logic                      issue_ready;
  logic [NUM_CDB-1:0]        cdb_valid = '0;
  logic [NUM_CDB*TAG_W-1:0]  cdb_tag = '0;
  logic [NUM_CDB*DATA_W-1:0] cdb_data = '0;
  logic                      alu_valid;
  logic                      alu_ready = 1'b0;
  logic [OP_W-1:0]           alu_op;
  logic [DATA_W-1:0]         alu_a, alu_b;
  logic [TAG_W-1:0]          alu_tag;
  logic [CNT_W-1:0]          count;
  logic                      overflow_err;

  rs_age_station #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W),
    .NUM_CDB(NUM_CDB), .AF_MARGIN(AF_MARGIN)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj_valid(issue_qj_valid), .issue_qk_valid(issue_qk_valid),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_tag(issue_tag),
    .issue_ready(issue_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_tag(alu_tag),
    .count(count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: entries kept in allocation order, so the oldest ready op
  // is simply the first ready element of the queue.
  typedef struct {
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] vj, vk;
    bit                pj, pk;
    logic [TAG_W-1:0]  qj, qk;
  } ent_t;

  ent_t              q_ent[$];
  bit                m_av = 0, m_ovf = 0, m_ir = 0;
  logic [OP_W-1:0]   m_op = '0;
  logic [DATA_W-1:0] m_a = '0, m_b = '0;
  logic [TAG_W-1:0]  m_tag = '0;

  function automatic bit cdb_lookup(input logic [TAG_W-1:0] t, output logic [DATA_W-1:0] d);
    d = '0;
    for (int p = 0; p < NUM_CDB; p++) begin
      if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == t) begin
        d = cdb_data[p*DATA_W +: DATA_W];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_step();
    ent_t e;
    int sel;
    bit can_load, accept;
    logic [DATA_W-1:0] d;
    if (rst) begin
      q_ent.delete();
      m_av = 0; m_op = '0; m_a = '0; m_b = '0; m_tag = '0; m_ovf = 0; m_ir = 0;
    end else if (rdy) begin
      if (flush) begin
        q_ent.delete();
        m_av = 0;
        m_ir = 1;
      end else begin
        sel = -1;
        for (int i = 0; i < q_ent.size(); i++) begin
          if (!q_ent[i].pj && !q_ent[i].pk) begin
            sel = i;
            break;
          end
        end
        can_load = !m_av || alu_ready;
        accept   = issue_valid && (q_ent.size() < DEPTH);
        if (issue_valid && !accept) m_ovf = 1;
        for (int i = 0; i < q_ent.size(); i++) begin
          e = q_ent[i];
          if (e.pj && cdb_lookup(e.qj, d)) begin e.vj = d; e.pj = 0; end
          if (e.pk && cdb_lookup(e.qk, d)) begin e.vk = d; e.pk = 0; end
          q_ent[i] = e;
        end
        if (can_load) begin
          if (sel >= 0) begin
            e = q_ent[sel];
            m_av = 1; m_op = e.op; m_a = e.vj; m_b = e.vk; m_tag = e.tag;
            q_ent.delete(sel);
          end else begin
            m_av = 0;
          end
        end
        if (accept) begin
          e.op = issue_op; e.tag = issue_tag;
          e.vj = issue_vj; e.vk = issue_vk;
          e.pj = issue_qj_valid; e.qj = issue_qj;
          e.pk = issue_qk_valid; e.qk = issue_qk;
          if (e.pj && cdb_lookup(e.qj, d)) begin e.vj = d; e.pj = 0; end
          if (e.pk && cdb_lookup(e.qk, d)) begin e.vk = d; e.pk = 0; end
          q_ent.push_back(e);
        end
        m_ir = (q_ent.size() <= DEPTH - AF_MARGIN);
      end
    end
  endtask

  task automatic compare_all();
    check_eq("alu_valid", alu_valid, m_av);
    check_eq("alu_op", alu_op, m_op);
    check_eq("alu_a", alu_a, m_a);
    check_eq("alu_b", alu_b, m_b);
    check_eq("alu_tag", alu_tag, m_tag);
    check_eq("count", count, q_ent.size());
    check_eq("issue_ready", issue_ready, m_ir);
    check_eq("overflow_err", overflow_err, m_ovf);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    issue_valid = 0; issue_qj_valid = 0; issue_qk_valid = 0;
    cdb_valid = '0; flush = 0;
  endtask

  task automatic put(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] tag,
                     input logic [DATA_W-1:0] vj, input logic [DATA_W-1:0] vk,
                     input bit pj, input logic [TAG_W-1:0] qj,
                     input bit pk, input logic [TAG_W-1:0] qk);
    issue_valid = 1; issue_op = op; issue_tag = tag;
    issue_vj = vj; issue_vk = vk;
    issue_qj_valid = pj; issue_qj = qj;
    issue_qk_valid = pk; issue_qk = qk;
  endtask

  task automatic do_reset();
    idle();
    rst = 1; rdy = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic rand_inputs();
    issue_valid    = ($urandom_range(0, 99) < 55);
    issue_op       = OP_W'($urandom);
    issue_tag      = TAG_W'($urandom);
    issue_vj       = $urandom;
    issue_vk       = $urandom;
    issue_qj_valid = ($urandom_range(0, 99) < 40);
    issue_qk_valid = ($urandom_range(0, 99) < 40);
    issue_qj       = TAG_W'($urandom_range(0, 7));
    issue_qk       = TAG_W'($urandom_range(0, 7));
    cdb_valid      = NUM_CDB'($urandom);
    for (int p = 0; p < NUM_CDB; p++) begin
      cdb_tag[p*TAG_W +: TAG_W]   = TAG_W'($urandom_range(0, 7));
      cdb_data[p*DATA_W +: DATA_W] = $urandom;
    end
    alu_ready = ($urandom_range(0, 99) < 60);
  endtask

  initial begin
    // Reset values, then credit one cycle after release
    do_reset();
    check_eq("rst_alu_valid", alu_valid, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_issue_ready", issue_ready, 0);
    check_eq("rst_overflow", overflow_err, 0);
    alu_ready = 0;
    tick();
    check_eq("ir_after_rst", issue_ready, 1);

    // Fill to capacity with the ALU stalled, then overflow
    for (int k = 0; k < 17; k++) begin
      put(OP_W'(k), TAG_W'(k % 16), 32'(k * 3 + 1), 32'(k + 100), 0, '0, 0, '0);
      tick();
    end
    put(5'd31, 4'd15, 32'hABCD, 32'h1, 0, '0, 0, '0);
    tick();
    idle();
    check_eq("s1_count", count, 16);
    check_eq("s1_overflow", overflow_err, 1);
    check_eq("s1_held_tag", alu_tag, 0);
    check_eq("s1_issue_ready", issue_ready, 0);
    tick();

    // Older op blocked on a tag, younger ready op goes first
    do_reset();
    alu_ready = 1;
    put(5'd1, 4'd3, 32'h0, 32'h11, 1, 4'd5, 0, '0);
    tick();
    put(5'd2, 4'd7, 32'h22, 32'h33, 0, '0, 0, '0);
    tick();
    idle();
    cdb_valid = 2'b01; cdb_tag[3:0] = 4'd5; cdb_data[31:0] = 32'hDEAD;
    tick();
    idle();
    check_eq("s2_first_tag", alu_tag, 7);
    tick();
    check_eq("s2_second_tag", alu_tag, 3);
    check_eq("s2_second_a", alu_a, 32'hDEAD);
    repeat (3) tick();

    // Two waiters on one tag dispatch in age order
    do_reset();
    alu_ready = 1;
    put(5'd3, 4'd1, 32'h10, 32'h0, 0, '0, 1, 4'd6);
    tick();
    put(5'd4, 4'd2, 32'h20, 32'h0, 0, '0, 1, 4'd6);
    tick();
    idle();
    cdb_valid = 2'b10; cdb_tag[7:4] = 4'd6; cdb_data[63:32] = 32'h55;
    tick();
    idle();
    tick();
    check_eq("s3_c_tag", alu_tag, 1);
    check_eq("s3_c_b", alu_b, 32'h55);
    tick();
    check_eq("s3_d_tag", alu_tag, 2);
    check_eq("s3_d_b", alu_b, 32'h55);
    repeat (2) tick();

    // Issue-time forwarding from the CDB
    do_reset();
    alu_ready = 1;
    put(5'd6, 4'd4, 32'h0, 32'h77, 1, 4'd9, 0, '0);
    cdb_valid = 2'b10; cdb_tag[7:4] = 4'd9; cdb_data[63:32] = 32'h1234;
    tick();
    idle();
    tick();
    check_eq("s4_valid", alu_valid, 1);
    check_eq("s4_a", alu_a, 32'h1234);
    tick();

    // Flush beats a simultaneous issue and broadcast
    do_reset();
    alu_ready = 0;
    for (int k = 0; k < 7; k++) begin
      put(OP_W'(k + 8), TAG_W'(k), 32'(k), 32'(k * 2), 0, '0, 0, '0);
      tick();
    end
    idle();
    tick();
    check_eq("s5_pre_count", count, 6);
    put(5'd9, 4'd9, 32'h9, 32'h9, 1, 4'd1, 0, '0);
    cdb_valid = 2'b11;
    flush = 1;
    tick();
    idle();
    check_eq("s5_count", count, 0);
    check_eq("s5_alu_valid", alu_valid, 0);
    check_eq("s5_issue_ready", issue_ready, 1);
    tick();
    check_eq("s5_no_new_op", count, 0);

    // Freeze with rdy=0, then reset mid-stream
    for (int k = 0; k < 4; k++) begin
      put(OP_W'(k), TAG_W'(k), 32'(k), 32'(k), 0, '0, 0, '0);
      tick();
    end
    rdy = 0;
    for (int k = 0; k < 3; k++) begin
      rand_inputs();
      flush = k[0];
      tick();
    end
    check_eq("s6_frozen_count", count, 3);
    rdy = 0;
    rst = 1;
    rand_inputs();
    tick();
    rst = 0; rdy = 1;
    idle();
    check_eq("s6_rst_alu_valid", alu_valid, 0);
    check_eq("s6_rst_count", count, 0);
    check_eq("s6_rst_tag", alu_tag, 0);
    check_eq("s6_rst_overflow", overflow_err, 0);
    check_eq("s6_rst_issue_ready", issue_ready, 0);
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      rdy   = ($urandom_range(0, 99) < 90);
      flush = ($urandom_range(0, 99) < 2);
      rst   = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 0; rdy = 1;
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
